// File: rtl/icache_pf_ctrl.sv
// rtl/icache_pf_ctrl.sv - I-cache controller with out-of-order prefetch buffer and stream run-ahead
// Optional same-cycle forwarding of returning memory data to IF when ICACHE_FWD_EN is defined.
module icache_pf_ctrl #(
  parameter int PF_DEPTH  = 4,
  parameter int MEM_TAG_W = 4,
  parameter int IDX_W     = 5,
  parameter int BLK_OFF_W = 3,
  localparam int TAG_W    = 64 - IDX_W - BLK_OFF_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          if2Icache_addr_i,
  input  logic                 if2Icache_rd_req_i,
  input  logic                 cachemem_hit_i,
  input  logic [63:0]          cachemem_data_i,
  output logic                 Icache2if_vld_o,
  output logic [63:0]          Icache2if_data_o,
  output logic [IDX_W-1:0]     Ictrl2Icache_rd_idx_o,
  output logic [TAG_W-1:0]     Ictrl2Icache_rd_tag_o,
  output logic                 Ictrl2Icache_wr_en_o,
  output logic [IDX_W-1:0]     Ictrl2Icache_wr_idx_o,
  output logic [TAG_W-1:0]     Ictrl2Icache_wr_tag_o,
  output logic [63:0]          Ictrl2Icache_wr_data_o,
  output logic [63:0]          proc2Imem_addr_o,
  output logic [1:0]           proc2Imem_command_o,
  input  logic [MEM_TAG_W-1:0] Imem2proc_response_i,
  input  logic [MEM_TAG_W-1:0] Imem2proc_tag_i,
  input  logic [63:0]          Imem2proc_data_i
);

  localparam int SLOT_W = $clog2(PF_DEPTH);
  localparam logic [63:0] BLK     = 64'd1 << BLK_OFF_W;
  localparam logic [63:0] RUN_MAX = 64'(PF_DEPTH) << BLK_OFF_W;
  localparam logic [1:0]  BUS_NONE = 2'd0;
  localparam logic [1:0]  BUS_LOAD = 2'd1;

  logic                 d_vld, d_sent;
  logic [MEM_TAG_W-1:0] d_tag;
  logic [63:0]          d_addr;
  logic                 pf_vld  [PF_DEPTH];
  logic                 pf_sent [PF_DEPTH];
  logic [MEM_TAG_W-1:0] pf_tag  [PF_DEPTH];
  logic [63:0]          pf_addr [PF_DEPTH];
  logic [63:0]          pf_next, base;

  logic [63:0]       req_blk, cmp_addr, sel_addr, base_nxt, pf_next_upd;
  logic              miss, hard_miss, any_match, cmp_d, cmp_any;
  logic              sel_vld, issue_d, issue_pf, accept;
  logic              free_any, in_use, alloc, fwd;
  logic [SLOT_W-1:0] sel, free_sel, cmp_sel;

  always_comb begin
    req_blk   = if2Icache_addr_i & ~(BLK - 64'd1);
    miss      = if2Icache_rd_req_i & ~cachemem_hit_i;
    any_match = d_vld && (d_addr == req_blk);
    cmp_d     = (Imem2proc_tag_i != '0) && d_vld && d_sent && (d_tag == Imem2proc_tag_i);
    cmp_any   = cmp_d;
    cmp_addr  = cmp_d ? d_addr : 64'd0;
    cmp_sel   = '0;
    sel_vld   = 1'b0;
    sel       = '0;
    sel_addr  = 64'd0;
    free_any  = 1'b0;
    free_sel  = '0;
    for (int i = 0; i < PF_DEPTH; i++) begin
      if (pf_vld[i] && (pf_addr[i] == req_blk)) any_match = 1'b1;
      if ((Imem2proc_tag_i != '0) && pf_vld[i] && pf_sent[i] && (pf_tag[i] == Imem2proc_tag_i)) begin
        cmp_any  = 1'b1;
        cmp_addr = pf_addr[i];
        cmp_sel  = SLOT_W'(i);
      end
      if (pf_vld[i] && !pf_sent[i] && (!sel_vld || (pf_addr[i] < sel_addr))) begin
        sel_vld  = 1'b1;
        sel      = SLOT_W'(i);
        sel_addr = pf_addr[i];
      end
      if (!pf_vld[i] && !free_any) begin
        free_any = 1'b1;
        free_sel = SLOT_W'(i);
      end
    end
    hard_miss = miss && !any_match;

    // Demand always wins arbitration; a rejected prefetch is re-picked next cycle.
    issue_d  = d_vld && !d_sent;
    issue_pf = sel_vld && !issue_d;
    accept   = (issue_d || issue_pf) && (Imem2proc_response_i != '0);

    base_nxt    = base;
    pf_next_upd = pf_next;
    if (hard_miss) begin
      base_nxt    = req_blk;
      pf_next_upd = req_blk + BLK;
    end else if (if2Icache_rd_req_i && cachemem_hit_i) begin
      base_nxt = req_blk;
      if (pf_next <= req_blk) pf_next_upd = req_blk + BLK;
    end

    in_use = d_vld && (d_addr == pf_next_upd);
    for (int i = 0; i < PF_DEPTH; i++) begin
      if (pf_vld[i] && (pf_addr[i] == pf_next_upd)) in_use = 1'b1;
    end
    // Unsigned difference keeps the run-ahead window correct across address wrap.
    alloc = !hard_miss && free_any && ((pf_next_upd - base_nxt) <= RUN_MAX) && !in_use;

`ifdef ICACHE_FWD_EN
    fwd = miss && cmp_any && (cmp_addr == req_blk);
`else
    fwd = 1'b0;
`endif
  end

  assign Icache2if_vld_o        = (if2Icache_rd_req_i & cachemem_hit_i) | fwd;
  assign Icache2if_data_o       = fwd ? Imem2proc_data_i : cachemem_data_i;
  assign Ictrl2Icache_rd_idx_o  = if2Icache_addr_i[BLK_OFF_W +: IDX_W];
  assign Ictrl2Icache_rd_tag_o  = if2Icache_addr_i[63 -: TAG_W];
  assign Ictrl2Icache_wr_en_o   = cmp_any;
  assign Ictrl2Icache_wr_idx_o  = cmp_addr[BLK_OFF_W +: IDX_W];
  assign Ictrl2Icache_wr_tag_o  = cmp_addr[63 -: TAG_W];
  assign Ictrl2Icache_wr_data_o = cmp_any ? Imem2proc_data_i : 64'd0;
  assign proc2Imem_command_o    = (issue_d || issue_pf) ? BUS_LOAD : BUS_NONE;
  assign proc2Imem_addr_o       = issue_d ? d_addr : (issue_pf ? sel_addr : 64'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      d_vld   <= 1'b0;
      d_sent  <= 1'b0;
      d_tag   <= '0;
      d_addr  <= 64'd0;
      pf_next <= 64'd0;
      base    <= 64'd0;
      for (int i = 0; i < PF_DEPTH; i++) begin
        pf_vld[i]  <= 1'b0;
        pf_sent[i] <= 1'b0;
        pf_tag[i]  <= '0;
        pf_addr[i] <= 64'd0;
      end
    end else begin
      if (cmp_d) d_vld <= 1'b0;
      if (cmp_any && !cmp_d) pf_vld[cmp_sel] <= 1'b0;
      if (accept && issue_d) begin
        d_sent <= 1'b1;
        d_tag  <= Imem2proc_response_i;
      end
      if (accept && issue_pf) begin
        pf_sent[sel] <= 1'b1;
        pf_tag[sel]  <= Imem2proc_response_i;
      end
      if (hard_miss) begin
        d_vld  <= 1'b1;
        d_sent <= 1'b0;
        d_tag  <= '0;
        d_addr <= req_blk;
        // A slot accepted this very cycle is in flight and must stay to catch its return.
        for (int i = 0; i < PF_DEPTH; i++) begin
          if (pf_vld[i] && !pf_sent[i] && !(accept && issue_pf && (sel == SLOT_W'(i))))
            pf_vld[i] <= 1'b0;
        end
      end
      if (alloc) begin
        pf_vld[free_sel]  <= 1'b1;
        pf_sent[free_sel] <= 1'b0;
        pf_tag[free_sel]  <= '0;
        pf_addr[free_sel] <= pf_next_upd;
      end
      base    <= base_nxt;
      pf_next <= alloc ? (pf_next_upd + BLK) : pf_next_upd;
    end
  end

endmodule

// File: tb/tb_icache_pf_ctrl.sv
// tb/tb_icache_pf_ctrl.sv - directed self-checking bench for icache_pf_ctrl
module tb_icache_pf_ctrl;

  logic        clk, rst;
  logic [63:0] if_addr;
  logic        rd_req, hit;
  logic [63:0] cdata;
  logic        vld;
  logic [63:0] if_data;
  logic [4:0]  rd_idx, wr_idx;
  logic [55:0] rd_tag, wr_tag;
  logic        wr_en;
  logic [63:0] wr_data, mem_addr;
  logic [1:0]  cmd;
  logic [3:0]  resp, mtag;
  logic [63:0] mdata;

  int checks = 0;
  int failures = 0;

`ifdef ICACHE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  icache_pf_ctrl dut (
    .clk(clk), .rst(rst),
    .if2Icache_addr_i(if_addr), .if2Icache_rd_req_i(rd_req),
    .cachemem_hit_i(hit), .cachemem_data_i(cdata),
    .Icache2if_vld_o(vld), .Icache2if_data_o(if_data),
    .Ictrl2Icache_rd_idx_o(rd_idx), .Ictrl2Icache_rd_tag_o(rd_tag),
    .Ictrl2Icache_wr_en_o(wr_en), .Ictrl2Icache_wr_idx_o(wr_idx),
    .Ictrl2Icache_wr_tag_o(wr_tag), .Ictrl2Icache_wr_data_o(wr_data),
    .proc2Imem_addr_o(mem_addr), .proc2Imem_command_o(cmd),
    .Imem2proc_response_i(resp), .Imem2proc_tag_i(mtag), .Imem2proc_data_i(mdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic r, input logic [63:0] a, input logic h, input logic [63:0] cd,
                     input logic [3:0] rsp, input logic [3:0] tg, input logic [63:0] md);
    rd_req = r; if_addr = a; hit = h; cdata = cd; resp = rsp; mtag = tg; mdata = md;
    #2;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd", cmd, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_vld", vld, 0);
    rst = 1'b0;
  endtask

  logic [63:0] pf_exp [4];
  logic [3:0]  ret_tag [4];
  logic [4:0]  ret_idx [4];

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);

    // Hit after reset, then four prefetches issued back to back
    do_reset();
    drv(1, 64'h100, 1, 64'h1234, 0, 0, 0);
    check("a_hit_vld", vld, 1);
    check("a_hit_data", if_data, 64'h1234);
    check("a_hit_cmd", cmd, 0);
    check("a_rd_idx", rd_idx, 0);
    check("a_rd_tag", rd_tag, 1);
    step();
    pf_exp = '{64'h108, 64'h110, 64'h118, 64'h120};
    for (int i = 0; i < 4; i++) begin
      drv(1, 64'h100, 1, 64'h1234, 4'(i + 1), 0, 0);
      check("a_pf_cmd", cmd, 1);
      check("a_pf_addr", mem_addr, pf_exp[i]);
      step();
    end
    drv(1, 64'h100, 1, 64'h1234, 0, 0, 0);
    check("a_full_cmd", cmd, 0);

    // Hard miss, demand fill, then out-of-order prefetch returns
    do_reset();
    drv(1, 64'h200, 0, 0, 0, 0, 0);
    check("b_miss_cmd", cmd, 0);
    check("b_miss_vld", vld, 0);
    step();
    drv(1, 64'h200, 0, 0, 3, 0, 0);
    check("b_d_cmd", cmd, 1);
    check("b_d_addr", mem_addr, 64'h200);
    step();
    drv(1, 64'h200, 0, 64'h5555, 1, 3, 64'hDEAD);
    check("b_fill_en", wr_en, 1);
    check("b_fill_idx", wr_idx, 0);
    check("b_fill_tag", wr_tag, 2);
    check("b_fill_data", wr_data, 64'hDEAD);
    check("b_fwd_vld", vld, FWD ? 64'd1 : 64'd0);
    check("b_fwd_data", if_data, FWD ? 64'hDEAD : 64'h5555);
    check("b_pf0_addr", mem_addr, 64'h208);
    step();
    drv(1, 64'h200, 1, 64'hDEAD, 2, 0, 0);
    check("b_hit_vld", vld, 1);
    check("b_hit_data", if_data, 64'hDEAD);
    check("b_pf1_addr", mem_addr, 64'h210);
    step();
    drv(1, 64'h200, 1, 64'hDEAD, 3, 0, 0);
    check("b_pf2_addr", mem_addr, 64'h218);
    step();
    drv(1, 64'h200, 1, 64'hDEAD, 4, 0, 0);
    check("b_pf3_addr", mem_addr, 64'h220);
    step();
    ret_tag = '{4'd3, 4'd1, 4'd4, 4'd2};
    ret_idx = '{5'd3, 5'd1, 5'd4, 5'd2};
    for (int i = 0; i < 4; i++) begin
      drv(1, (i == 3) ? 64'h208 : 64'h200, 1, 0, 0, ret_tag[i], 64'hA0 + 64'(i));
      check("b_ret_en", wr_en, 1);
      check("b_ret_idx", wr_idx, ret_idx[i]);
      check("b_ret_tag", wr_tag, 2);
      check("b_ret_data", wr_data, 64'hA0 + 64'(i));
      check("b_ret_cmd", cmd, 0);
      step();
    end
    drv(1, 64'h208, 1, 0, 0, 7, 0);
    check("b_realloc_cmd", cmd, 1);
    check("b_realloc_addr", mem_addr, 64'h228);
    check("b_stray_tag_en", wr_en, 0);
    check("b_rd_idx", rd_idx, 1);
    step();
    drv(1, 64'h208, 1, 0, 0, 0, 0);
    check("b_retry_addr", mem_addr, 64'h228);

    // Demand rejected for five cycles, then mid-operation reset
    do_reset();
    drv(1, 64'h300, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      drv(1, 64'h300, 0, 0, 0, 0, 0);
      check("c_rej_cmd", cmd, 1);
      check("c_rej_addr", mem_addr, 64'h300);
      step();
    end
    drv(1, 64'h300, 0, 0, 5, 0, 0);
    check("c_acc_addr", mem_addr, 64'h300);
    step();
    drv(1, 64'h300, 0, 0, 0, 0, 0);
    check("c_pf_after_d", mem_addr, 64'h308);
    do_reset();
    drv(0, 0, 0, 0, 0, 5, 64'hBEEF);
    check("c_post_rst_en", wr_en, 0);
    check("c_post_rst_cmd", cmd, 0);

    // Hard miss drops an unsent prefetch; sent ones still fill
    do_reset();
    drv(1, 64'h200, 0, 0, 0, 0, 0);
    step();
    drv(1, 64'h200, 0, 0, 3, 0, 0);
    check("d_d_addr", mem_addr, 64'h200);
    step();
    drv(1, 64'h200, 0, 0, 1, 0, 0);
    check("d_pf0_addr", mem_addr, 64'h208);
    step();
    drv(1, 64'h200, 0, 0, 2, 0, 0);
    check("d_pf1_addr", mem_addr, 64'h210);
    step();
    drv(1, 64'h400, 0, 0, 0, 0, 0);
    check("d_pf2_addr", mem_addr, 64'h218);
    step();
    drv(1, 64'h400, 0, 0, 6, 3, 64'h77);
    check("d_new_d_addr", mem_addr, 64'h400);
    check("d_abandon_en", wr_en, 0);
    step();
    drv(1, 64'h400, 0, 0, 0, 1, 64'h88);
    check("d_skip_addr", mem_addr, 64'h408);
    check("d_fill0_en", wr_en, 1);
    check("d_fill0_idx", wr_idx, 1);
    check("d_fill0_tag", wr_tag, 2);
    check("d_fill0_data", wr_data, 64'h88);
    step();
    drv(1, 64'h400, 0, 0, 0, 2, 64'h99);
    check("d_fill1_en", wr_en, 1);
    check("d_fill1_idx", wr_idx, 2);
    check("d_pf_addr2", mem_addr, 64'h408);
    step();
    drv(1, 64'h400, 0, 64'h11, 0, 6, 64'h44);
    check("d_dfill_en", wr_en, 1);
    check("d_dfill_idx", wr_idx, 0);
    check("d_dfill_tag", wr_tag, 4);
    check("d_dfill_vld", vld, FWD ? 64'd1 : 64'd0);
    check("d_pf_addr3", mem_addr, 64'h408);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
